// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and default array geometry
// for the output-stationary systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    OUT
  } state_t;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

endpackage

// File: rtl/systolic_mac_pe.sv
// mac_pe: one output-stationary cell; registers the passing A/B
// operands with valid bits and accumulates their signed product.
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vin,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vin,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vout,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vout,
  output logic [ACC_W-1:0]  acc
);

  logic signed [DATA_W-1:0]   a_s;
  logic signed [DATA_W-1:0]   b_s;
  logic signed [2*DATA_W-1:0] prod;

  assign a_s  = a_out;
  assign b_s  = b_out;
  assign prod = (2*DATA_W)'(a_s) * (2*DATA_W)'(b_s);

  // pass operands on every cycle; accumulate only when both are valid
  always_ff @(posedge clk) begin
    if (clear) begin
      a_out  <= '0;
      a_vout <= 1'b0;
      b_out  <= '0;
      b_vout <= 1'b0;
      acc    <= '0;
    end else begin
      a_out  <= a_in;
      a_vout <= a_vin;
      b_out  <= b_in;
      b_vout <= b_vin;
      if (a_vout && b_vout)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// systolic_matmul: N x N output-stationary matrix multiplier with
// skewed operand feed, job FSM and row-major result readout.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_MAX  = 256,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int RW    = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic [N*DATA_W-1:0] b_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic [RW-1:0]       out_row,
  output logic [RW-1:0]       out_col,
  output logic                done
);

  localparam int CW = $clog2(2 * N);

  state_t        state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] k_cnt;
  logic          last_beat;
  logic [CW-1:0] d_cnt;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic          done_q;
  logic          accept;
  logic          pe_clear;

  logic [DATA_W-1:0] a_d [N][N+1];
  logic              a_v [N][N+1];
  logic [DATA_W-1:0] b_d [N+1][N];
  logic              b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];

  assign in_ready  = (state == FEED) && !last_beat;
  assign accept    = in_valid && in_ready;
  assign pe_clear  = reset || (state == IDLE && start);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_row   = row;
  assign out_col   = col;
  assign out_data  = acc[row][col];
  assign done      = done_q;

  for (genvar l = 0; l < N; l++) begin : g_skew
    logic [DATA_W:0] a_new;
    logic [DATA_W:0] b_new;
    assign a_new = {accept, a_vec[l*DATA_W +: DATA_W]};
    assign b_new = {accept, b_vec[l*DATA_W +: DATA_W]};
    if (l == 0) begin : g_direct
      assign {a_v[0][0], a_d[0][0]} = a_new;
      assign {b_v[0][0], b_d[0][0]} = b_new;
    end else begin : g_delay
      logic [DATA_W:0] a_sr [l];
      logic [DATA_W:0] b_sr [l];
      // delay lane l by l cycles so wavefronts meet on the diagonal
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < l; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_new;
          b_sr[0] <= b_new;
          for (int d = 1; d < l; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign {a_v[l][0], a_d[l][0]} = a_sr[l-1];
      assign {b_v[0][l], b_d[0][l]} = b_sr[l-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk    (clk),
        .clear  (pe_clear),
        .a_in   (a_d[i][j]),
        .a_vin  (a_v[i][j]),
        .b_in   (b_d[i][j]),
        .b_vin  (b_v[i][j]),
        .a_out  (a_d[i][j+1]),
        .a_vout (a_v[i][j+1]),
        .b_out  (b_d[i+1][j]),
        .b_vout (b_v[i+1][j]),
        .acc    (acc[i][j])
      );
    end
  end

  // job sequencing: feed k beats, drain the skew, then stream results
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_lat     <= '0;
      k_cnt     <= '0;
      last_beat <= 1'b0;
      d_cnt     <= '0;
      row       <= '0;
      col       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            k_cnt     <= '0;
            last_beat <= 1'b0;
            d_cnt     <= '0;
            row       <= '0;
            col       <= '0;
            k_lat     <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
            state     <= (k_len == '0) ? OUT : FEED;
          end
        end
        FEED: begin
          if (last_beat) begin
            state <= DRAIN;
            d_cnt <= '0;
          end else if (accept) begin
            k_cnt <= k_cnt + KW'(1);
            if (k_cnt + KW'(1) == k_lat)
              last_beat <= 1'b1;
          end
        end
        DRAIN: begin
          if (d_cnt == CW'(2 * N - 2))
            state <= OUT;
          else
            d_cnt <= d_cnt + CW'(1);
        end
        OUT: begin
          if (out_ready) begin
            if (row == RW'(N - 1) && col == RW'(N - 1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
              row    <= '0;
              col    <= '0;
            end else if (col == RW'(N - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
